// File: rtl/mem_arb_types.sv
// Shared types for the instruction/data memory arbiter.
package mem_arb_types;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_INST = 2'd1,
      SERVE_DATA = 2'd2
   } arb_state_t;

   typedef enum logic {
      INST = 1'b0,
      DATA = 1'b1
   } grant_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } mem_op_t;

endpackage

// File: rtl/mem_req_reg.sv
// Latched copy of the granted request; mem_* outputs are driven from here,
// so requester activity during a transaction cannot disturb the memory port.
module mem_req_reg
   import mem_arb_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] next_address,
   input  logic [31:0] next_wdata,
   input  logic [3:0]  next_byte_enable,
   input  mem_op_t     next_op,
   output logic [31:0] address,
   output logic [31:0] wdata,
   output logic [3:0]  byte_enable,
   output mem_op_t     op
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         address     <= '0;
         wdata       <= '0;
         byte_enable <= '0;
         op          <= OP_READ;
      end else if (load) begin
         address     <= next_address;
         wdata       <= next_wdata;
         byte_enable <= next_byte_enable;
         op          <= next_op;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one memory port; one outstanding
// transaction, grant in IDLE, resp forwarded combinationally, IDLE after resp.
module mem_arbiter
   import mem_arb_types::*;
#(
   parameter int PRIORITY_MODE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_mem_address,
   input  logic        inst_mem_read,
   input  logic        inst_mem_write,
   input  logic [3:0]  inst_mem_byte_enable,
   input  logic [31:0] inst_mem_wdata,
   output logic [31:0] inst_mem_rdata,
   output logic        inst_mem_resp,
   input  logic [31:0] data_mem_address,
   input  logic        data_mem_read,
   input  logic        data_mem_write,
   input  logic [3:0]  data_mem_byte_enable,
   input  logic [31:0] data_mem_wdata,
   output logic [31:0] data_mem_rdata,
   output logic        data_mem_resp,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   output logic        arb_busy
);

   arb_state_t  state, next_state;
   grant_t      last_grant;
   grant_t      grant_sel;
   logic        grant_en;
   logic        inst_req, data_req;
   logic [31:0] next_address, next_wdata;
   logic [3:0]  next_byte_enable;
   mem_op_t     next_op;
   mem_op_t     req_op;

   assign inst_req = inst_mem_read | inst_mem_write;
   assign data_req = data_mem_read | data_mem_write;

   always_comb begin
      next_state = state;
      grant_en   = 1'b0;
      grant_sel  = DATA;
      case (state)
         IDLE: begin
            if (inst_req && data_req) begin
               if (PRIORITY_MODE != 0) grant_sel = DATA;
               else                    grant_sel = (last_grant == DATA) ? INST : DATA;
            end else if (inst_req) begin
               grant_sel = INST;
            end
            if (inst_req || data_req) begin
               grant_en   = 1'b1;
               next_state = (grant_sel == DATA) ? SERVE_DATA : SERVE_INST;
            end
         end
         SERVE_INST, SERVE_DATA: begin
            if (mem_resp) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Write strobe dominates when a port raises both.
   always_comb begin
      if (grant_sel == DATA) begin
         next_address     = data_mem_address;
         next_wdata       = data_mem_wdata;
         next_byte_enable = data_mem_byte_enable;
         next_op          = data_mem_write ? OP_WRITE : OP_READ;
      end else begin
         next_address     = inst_mem_address;
         next_wdata       = inst_mem_wdata;
         next_byte_enable = inst_mem_byte_enable;
         next_op          = inst_mem_write ? OP_WRITE : OP_READ;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= DATA;
      end else begin
         state <= next_state;
         if (grant_en) last_grant <= grant_sel;
      end
   end

   mem_req_reg u_req_reg (
      .clk              (clk),
      .rst              (rst),
      .load             (grant_en),
      .next_address     (next_address),
      .next_wdata       (next_wdata),
      .next_byte_enable (next_byte_enable),
      .next_op          (next_op),
      .address          (mem_address),
      .wdata            (mem_wdata),
      .byte_enable      (mem_byte_enable),
      .op               (req_op)
   );

   assign arb_busy       = (state != IDLE);
   assign mem_read       = arb_busy && (req_op == OP_READ);
   assign mem_write      = arb_busy && (req_op == OP_WRITE);
   assign inst_mem_resp  = (state == SERVE_INST) && mem_resp;
   assign data_mem_resp  = (state == SERVE_DATA) && mem_resp;
   assign inst_mem_rdata = mem_rdata;
   assign data_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter share one stimulus set.
`timescale 1ns/100ps
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] inst_address = '0, inst_wdata = '0, data_address = '0, data_wdata = '0;
   logic        inst_read = 1'b0, inst_write = 1'b0, data_read = 1'b0, data_write = 1'b0;
   logic [3:0]  inst_be = '0, data_be = '0;
   logic [31:0] mem_rdata = '0;
   logic        mem_resp = 1'b0;

   logic [31:0] p_inst_rdata, p_data_rdata, p_mem_address, p_mem_wdata;
   logic        p_inst_resp, p_data_resp, p_mem_read, p_mem_write, p_busy;
   logic [3:0]  p_mem_be;
   logic [31:0] r_inst_rdata, r_data_rdata, r_mem_address, r_mem_wdata;
   logic        r_inst_resp, r_data_resp, r_mem_read, r_mem_write, r_busy;
   logic [3:0]  r_mem_be;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.PRIORITY_MODE(1)) dut_prio (
      .clk(clk), .rst(rst),
      .inst_mem_address(inst_address), .inst_mem_read(inst_read), .inst_mem_write(inst_write),
      .inst_mem_byte_enable(inst_be), .inst_mem_wdata(inst_wdata),
      .inst_mem_rdata(p_inst_rdata), .inst_mem_resp(p_inst_resp),
      .data_mem_address(data_address), .data_mem_read(data_read), .data_mem_write(data_write),
      .data_mem_byte_enable(data_be), .data_mem_wdata(data_wdata),
      .data_mem_rdata(p_data_rdata), .data_mem_resp(p_data_resp),
      .mem_address(p_mem_address), .mem_read(p_mem_read), .mem_write(p_mem_write),
      .mem_byte_enable(p_mem_be), .mem_wdata(p_mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .arb_busy(p_busy)
   );

   mem_arbiter #(.PRIORITY_MODE(0)) dut_rr (
      .clk(clk), .rst(rst),
      .inst_mem_address(inst_address), .inst_mem_read(inst_read), .inst_mem_write(inst_write),
      .inst_mem_byte_enable(inst_be), .inst_mem_wdata(inst_wdata),
      .inst_mem_rdata(r_inst_rdata), .inst_mem_resp(r_inst_resp),
      .data_mem_address(data_address), .data_mem_read(data_read), .data_mem_write(data_write),
      .data_mem_byte_enable(data_be), .data_mem_wdata(data_wdata),
      .data_mem_rdata(r_data_rdata), .data_mem_resp(r_data_resp),
      .mem_address(r_mem_address), .mem_read(r_mem_read), .mem_write(r_mem_write),
      .mem_byte_enable(r_mem_be), .mem_wdata(r_mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .arb_busy(r_busy)
   );

   task automatic clear_inputs();
      inst_read = 1'b0; inst_write = 1'b0; data_read = 1'b0; data_write = 1'b0;
      inst_address = '0; data_address = '0; inst_wdata = '0; data_wdata = '0;
      inst_be = '0; data_be = '0; mem_resp = 1'b0; mem_rdata = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      mem_resp = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (p_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", p_busy); end
      checks++; if ({p_mem_read, p_mem_write} !== 2'b00) begin errors++; $display("FAIL reset_rw: got %b want 00", {p_mem_read, p_mem_write}); end
      checks++; if ({p_inst_resp, p_data_resp, r_inst_resp, r_data_resp} !== 4'b0000) begin errors++; $display("FAIL reset_resp: got %b want 0000", {p_inst_resp, p_data_resp, r_inst_resp, r_data_resp}); end
      checks++; if (p_mem_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", p_mem_address); end
      mem_resp = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_inst_read();
      apply_reset();
      inst_address = 32'h0000_0060;
      inst_read    = 1'b1;
      @(negedge clk); #1;
      checks++; if ({p_busy, p_mem_read, p_mem_write} !== 3'b110) begin errors++; $display("FAIL ir_serve: busy/rd/wr got %b want 110", {p_busy, p_mem_read, p_mem_write}); end
      checks++; if (p_mem_address !== 32'h0000_0060) begin errors++; $display("FAIL ir_addr: got %h want 00000060", p_mem_address); end
      repeat (2) @(negedge clk);
      mem_rdata = 32'h0000_0013;
      mem_resp  = 1'b1;
      #1;
      checks++; if ({p_inst_resp, p_data_resp} !== 2'b10) begin errors++; $display("FAIL ir_resp: inst/data got %b want 10", {p_inst_resp, p_data_resp}); end
      checks++; if (p_inst_rdata !== 32'h0000_0013) begin errors++; $display("FAIL ir_rdata: got %h want 00000013", p_inst_rdata); end
      @(negedge clk);
      inst_read = 1'b0;
      mem_resp  = 1'b0;
      #1;
      checks++; if ({p_inst_resp, p_busy, p_mem_read} !== 3'b000) begin errors++; $display("FAIL ir_done: resp/busy/rd got %b want 000", {p_inst_resp, p_busy, p_mem_read}); end
   endtask

   task automatic test_priority();
      apply_reset();
      inst_address = 32'h100; inst_read  = 1'b1;
      data_address = 32'h200; data_write = 1'b1; data_wdata = 32'hDEAD_BEEF; data_be = 4'hF;
      @(negedge clk); #1;
      checks++; if ({p_mem_write, p_mem_read} !== 2'b10) begin errors++; $display("FAIL pr_op: wr/rd got %b want 10", {p_mem_write, p_mem_read}); end
      checks++; if (p_mem_address !== 32'h200) begin errors++; $display("FAIL pr_addr: got %h want 00000200", p_mem_address); end
      checks++; if ({p_mem_wdata, p_mem_be} !== {32'hDEAD_BEEF, 4'hF}) begin errors++; $display("FAIL pr_wdata: got %h/%h want deadbeef/f", p_mem_wdata, p_mem_be); end
      checks++; if (r_mem_address !== 32'h100) begin errors++; $display("FAIL pr_rr_first: got %h want 00000100", r_mem_address); end
      mem_resp = 1'b1;
      #1;
      checks++; if ({p_data_resp, p_inst_resp} !== 2'b10) begin errors++; $display("FAIL pr_resp1: data/inst got %b want 10", {p_data_resp, p_inst_resp}); end
      @(negedge clk);
      data_write = 1'b0;
      mem_resp   = 1'b0;
      #1;
      checks++; if (p_busy !== 1'b0) begin errors++; $display("FAIL pr_idle: got %b want 0", p_busy); end
      @(negedge clk); #1;
      checks++; if ({p_mem_read, p_mem_write, p_mem_address} !== {2'b10, 32'h100}) begin errors++; $display("FAIL pr_second: rd/wr/addr got %b/%b/%h want 1/0/00000100", p_mem_read, p_mem_write, p_mem_address); end
      mem_resp = 1'b1;
      #1;
      checks++; if ({p_inst_resp, p_data_resp} !== 2'b10) begin errors++; $display("FAIL pr_resp2: inst/data got %b want 10", {p_inst_resp, p_data_resp}); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_addr;
      apply_reset();
      inst_address = 32'h100; inst_read = 1'b1;
      data_address = 32'h200; data_read = 1'b1;
      mem_resp     = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
         checks++; if ({r_inst_resp, r_data_resp} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d: inst/data resp got %b", k, {r_inst_resp, r_data_resp}); end
         checks++; if (r_mem_address !== exp_addr) begin errors++; $display("FAIL rr_addr%0d: got %h want %h", k, r_mem_address, exp_addr); end
         checks++; if ({p_data_resp, p_inst_resp} !== 2'b10) begin errors++; $display("FAIL rr_prio%0d: data/inst got %b want 10", k, {p_data_resp, p_inst_resp}); end
         @(negedge clk); #1;
         checks++; if (r_busy !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: got %b want 0", k, r_busy); end
      end
      clear_inputs();
   endtask

   task automatic test_hold();
      apply_reset();
      data_address = 32'h200; data_write = 1'b1; data_wdata = 32'h1234_5678; data_be = 4'h3;
      @(negedge clk);
      data_address = 32'h300; data_write = 1'b0; data_read = 1'b1; data_wdata = 32'hFFFF_0000;
      #1;
      checks++; if ({p_mem_write, p_mem_read, p_mem_address} !== {2'b10, 32'h200}) begin errors++; $display("FAIL hold_a: wr/rd/addr got %b/%b/%h want 1/0/00000200", p_mem_write, p_mem_read, p_mem_address); end
      @(negedge clk); #1;
      checks++; if ({p_mem_address, p_mem_wdata, p_mem_be} !== {32'h200, 32'h1234_5678, 4'h3}) begin errors++; $display("FAIL hold_b: got %h/%h/%h want 00000200/12345678/3", p_mem_address, p_mem_wdata, p_mem_be); end
      mem_resp = 1'b1;
      #1;
      checks++; if (p_data_resp !== 1'b1) begin errors++; $display("FAIL hold_resp: got %b want 1", p_data_resp); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      data_address = 32'h200; data_write = 1'b1; data_wdata = 32'hA5A5_A5A5; data_be = 4'hF;
      @(negedge clk); #1;
      checks++; if (p_mem_write !== 1'b1) begin errors++; $display("FAIL rm_serve: got %b want 1", p_mem_write); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({p_mem_write, p_busy} !== 2'b00) begin errors++; $display("FAIL rm_async: wr/busy got %b want 00", {p_mem_write, p_busy}); end
      data_write = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      checks++; if ({p_data_resp, p_inst_resp, p_busy} !== 3'b000) begin errors++; $display("FAIL rm_late_resp: resp/busy got %b want 000", {p_data_resp, p_inst_resp, p_busy}); end
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      checks++; if ({p_busy, p_mem_write} !== 2'b00) begin errors++; $display("FAIL rm_stay_idle: busy/wr got %b want 00", {p_busy, p_mem_write}); end
   endtask

   initial begin
      test_reset();
      test_inst_read();
      test_priority();
      test_round_robin();
      test_hold();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
